// File: rtl/debug_frame_uart_if.sv
// debug_frame_uart_if: signal bundle for the debug frame UART.
//   data_in             word to transmit (sampled at frame start)
//   debug_uart_rx_in    UART RX line, idle high
//   debug_command       last correctly received command byte
//   debug_command_pulse one-cycle strobe on debug_command update
//   debug_command_busy  high while a TX frame is in progress
//   tx_out              UART TX line, idle high
// Modports: slave = the UART block, master = whoever feeds/observes it.
interface debug_frame_uart_if #(
  parameter int DATA_WIDTH = 8320
) ();
  logic [DATA_WIDTH-1:0] data_in;
  logic                  debug_uart_rx_in;
  logic [7:0]            debug_command;
  logic                  debug_command_pulse;
  logic                  debug_command_busy;
  logic                  tx_out;

  modport slave (
    input  data_in,
    input  debug_uart_rx_in,
    output debug_command,
    output debug_command_pulse,
    output debug_command_busy,
    output tx_out
  );

  modport master (
    output data_in,
    output debug_uart_rx_in,
    input  debug_command,
    input  debug_command_pulse,
    input  debug_command_busy,
    input  tx_out
  );
endinterface

// File: rtl/debug_frame_uart.sv
// debug_frame_uart: periodically snapshots a wide word and streams it out as
// 8N1 UART bytes (MSB byte first, LSB bit first); optionally receives
// single-byte commands on an RX line.
// Ports:
//   clk_in  system clock
//   reset   synchronous, active-low reset
//   bus     debug_frame_uart_if.slave (data_in, debug_uart_rx_in,
//           debug_command, debug_command_pulse, debug_command_busy, tx_out)
// Build option: define DEBUGGER_RX_EN to include the command receiver;
// without it debug_command stays 8'h00 and the pulse stays low.
module debug_frame_uart #(
  parameter int DATA_WIDTH_BASE2        = 14,
  parameter int DATA_WIDTH              = 8320,
  parameter int DIVIDER_TICKS_WIDTH     = 20,
  parameter int DIVIDER_TICKS           = 727273,
  parameter int UART_TICKS_PER_BIT      = 139,
  parameter int UART_TICKS_PER_BIT_SIZE = 8
) (
  input  logic                clk_in,
  input  logic                reset,
  debug_frame_uart_if.slave   bus
);
  localparam logic [DIVIDER_TICKS_WIDTH-1:0] DIV_LAST =
    DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1);
  localparam logic [UART_TICKS_PER_BIT_SIZE-1:0] BIT_LAST =
    UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT - 1);
  localparam logic [DATA_WIDTH_BASE2-1:0] LAST_BYTE =
    DATA_WIDTH_BASE2'(DATA_WIDTH / 8 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // ---------------- frame-rate divider ----------------
  logic [DIVIDER_TICKS_WIDTH-1:0] div_q, div_d;
  logic                           tick_s;

  assign tick_s = (div_q == DIV_LAST);
  assign div_d  = tick_s ? '0 : div_q + DIVIDER_TICKS_WIDTH'(1);

  // Divider register.
  always_ff @(posedge clk_in) begin
    if (!reset) div_q <= '0;
    else        div_q <= div_d;
  end

  // ---------------- transmitter ----------------
  state_e                             tx_state_q, tx_state_d;
  logic [UART_TICKS_PER_BIT_SIZE-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]                         tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH_BASE2-1:0]        tx_bytes_q, tx_bytes_d;
  logic [DATA_WIDTH-1:0]              shadow_q, shadow_d;
  logic                               tx_q, tx_d;
  logic                               busy_q, busy_d;
  logic [7:0]                         tx_byte_s;

  // The byte on the wire is always the top byte; the shadow shifts up per byte.
  assign tx_byte_s = shadow_q[DATA_WIDTH-1 -: 8];

  // TX state register; tx_out and busy are registered here.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= 3'd0;
      tx_bytes_q <= '0;
      shadow_q   <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_bytes_q <= tx_bytes_d;
      shadow_q   <= shadow_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // TX next-state: tx_d is the level the line takes from the next edge on.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q + UART_TICKS_PER_BIT_SIZE'(1);
    tx_bit_d   = tx_bit_q;
    tx_bytes_d = tx_bytes_q;
    shadow_d   = shadow_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    case (tx_state_q)
      ST_IDLE: begin
        tx_baud_d = '0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        if (tick_s) begin
          tx_state_d = ST_START;
          shadow_d   = bus.data_in;
          tx_bytes_d = LAST_BYTE;
          tx_bit_d   = 3'd0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end else begin
          tx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tx_baud_q == BIT_LAST) begin
          tx_baud_d  = '0;
          tx_state_d = ST_DATA;
          tx_d       = tx_byte_s[tx_bit_q];
        end else begin
          tx_state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tx_baud_q == BIT_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_d     = tx_byte_s[tx_bit_q + 3'd1];
          end
        end else begin
          tx_state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tx_baud_q == BIT_LAST) begin
          tx_baud_d = '0;
          if (tx_bytes_q == '0) begin
            tx_state_d = ST_IDLE;
            busy_d     = 1'b0;
            tx_d       = 1'b1;
          end else begin
            // Next byte follows immediately with its start bit.
            tx_state_d = ST_START;
            tx_bytes_d = tx_bytes_q - DATA_WIDTH_BASE2'(1);
            shadow_d   = {shadow_q[DATA_WIDTH-9:0], 8'h00};
            tx_bit_d   = 3'd0;
            tx_d       = 1'b0;
          end
        end else begin
          tx_state_d = ST_STOP;
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign bus.tx_out             = tx_q;
  assign bus.debug_command_busy = busy_q;

`ifdef DEBUGGER_RX_EN
  // ---------------- receiver ----------------
  localparam logic [UART_TICKS_PER_BIT_SIZE-1:0] HALF_LAST =
    UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT / 2 - 1);

  state_e                             rx_state_q, rx_state_d;
  logic [UART_TICKS_PER_BIT_SIZE-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]                         rx_bit_q, rx_bit_d;
  logic [7:0]                         rx_shift_q, rx_shift_d;
  logic [7:0]                         cmd_q, cmd_d;
  logic                               pulse_q, pulse_d;
  logic                               rx_meta_q, rx_sync_q, rx_prev_q;

  // Synchronizer plus edge-detect history. All reset low so a line that is
  // low at reset exit must first be seen high before a falling edge counts.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= bus.debug_uart_rx_in;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX state register.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      rx_state_q <= ST_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      cmd_q      <= 8'h00;
      pulse_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      cmd_q      <= cmd_d;
      pulse_q    <= pulse_d;
    end
  end

  // RX next-state: half-bit start check, then one sample per bit period.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q + UART_TICKS_PER_BIT_SIZE'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    cmd_d      = cmd_q;
    pulse_d    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_baud_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = ST_START;
        else                         rx_state_d = ST_IDLE;
      end
      ST_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d = '0;
          rx_bit_d  = 3'd0;
          if (rx_sync_q) rx_state_d = ST_IDLE;
          else           rx_state_d = ST_DATA;
        end else begin
          rx_state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (rx_baud_q == BIT_LAST) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (rx_baud_q == BIT_LAST) begin
          rx_baud_d  = '0;
          rx_state_d = ST_IDLE;
          // A low stop bit drops the byte; IDLE then waits for a high line.
          if (rx_sync_q) begin
            cmd_d   = rx_shift_q;
            pulse_d = 1'b1;
          end else begin
            cmd_d = cmd_q;
          end
        end else begin
          rx_state_d = ST_STOP;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  assign bus.debug_command       = cmd_q;
  assign bus.debug_command_pulse = pulse_q;
`else
  // Receiver omitted: the RX line is ignored and command outputs are zero.
  logic unused_rx_s;
  assign unused_rx_s             = bus.debug_uart_rx_in;
  assign bus.debug_command       = 8'h00;
  assign bus.debug_command_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_debug_frame_uart.sv
// Testbench for debug_frame_uart: a queue-based frame model predicts tx_out
// and busy every cycle; RX commands are checked by pulse count and value.
module tb_debug_frame_uart;
  localparam int DW    = 16;
  localparam int BASE2 = 5;
  localparam int DTW   = 8;
  localparam int DT    = 15;
  localparam int UPB   = 4;
  localparam int UPBS  = 8;
  localparam int FRAME = (DW / 8) * 10 * UPB;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_in = ~clk_in;

  debug_frame_uart_if #(.DATA_WIDTH(DW)) bus ();

  debug_frame_uart #(
    .DATA_WIDTH_BASE2(BASE2), .DATA_WIDTH(DW), .DIVIDER_TICKS_WIDTH(DTW),
    .DIVIDER_TICKS(DT), .UART_TICKS_PER_BIT(UPB), .UART_TICKS_PER_BIT_SIZE(UPBS)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   vectors    = 0;
  int   miscompares = 0;
  int   m_div      = 0;
  bit   m_busy     = 1'b0;
  bit   exp_q[$];
  int   busy_run   = 0;
  int   pulse_cnt  = 0;
  logic [7:0] m_cmd = 8'h00;

`ifdef DEBUGGER_RX_EN
  localparam bit RX_ON = 1'b1;
`else
  localparam bit RX_ON = 1'b0;
`endif

  // Expected line levels for a whole frame built from a snapshot.
  task automatic load_frame(input logic [DW-1:0] d);
    logic [7:0] b;
    for (int k = 0; k < DW / 8; k++) begin
      b = d[DW-1-8*k -: 8];
      repeat (UPB) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (UPB) exp_q.push_back(b[i]);
      repeat (UPB) exp_q.push_back(1'b1);
    end
  endtask

  // One clock: advance the model with inputs as seen at the edge, then check.
  task automatic step();
    logic [DW-1:0] d_at;
    logic r_at;
    bit   tick;
    bit   exp_tx;
    d_at = bus.data_in;
    r_at = reset;
    @(posedge clk_in);
    #1;
    if (!r_at) begin
      m_div = 0;
      exp_q.delete();
      m_busy = 1'b0;
      exp_tx = 1'b1;
    end else begin
      tick  = (m_div == DT - 1);
      m_div = (m_div + 1) % DT;
      if (tick && !m_busy) load_frame(d_at);
      if (exp_q.size() > 0) begin
        exp_tx = exp_q.pop_front();
        m_busy = 1'b1;
      end else begin
        exp_tx = 1'b1;
        m_busy = 1'b0;
      end
    end
    vectors++;
    assert (bus.tx_out === exp_tx) else begin
      miscompares++;
      $error("FAIL tx_out: got %b expected %b", bus.tx_out, exp_tx);
    end
    vectors++;
    assert (bus.debug_command_busy === m_busy) else begin
      miscompares++;
      $error("FAIL busy: got %b expected %b", bus.debug_command_busy, m_busy);
    end
    if (bus.debug_command_busy === 1'b1) begin
      busy_run++;
    end else begin
      if (busy_run != 0) begin
        if (r_at) begin
          vectors++;
          assert (busy_run == FRAME) else begin
            miscompares++;
            $error("FAIL busy_len: got %0d expected %0d", busy_run, FRAME);
          end
        end
        busy_run = 0;
      end
    end
    if (bus.debug_command_pulse === 1'b1) pulse_cnt++;
  endtask

  // Send one RX byte; a bad stop bit holds the line low a while first.
  task automatic rx_send(input logic [7:0] b, input bit stop_ok);
    int exp_pulses;
    pulse_cnt = 0;
    bus.debug_uart_rx_in = 1'b0;
    repeat (UPB) step();
    for (int i = 0; i < 8; i++) begin
      bus.debug_uart_rx_in = b[i];
      repeat (UPB) step();
    end
    bus.debug_uart_rx_in = stop_ok;
    repeat (UPB) step();
    if (!stop_ok) repeat (12) step();
    bus.debug_uart_rx_in = 1'b1;
    repeat (12) step();
    exp_pulses = (RX_ON && stop_ok) ? 1 : 0;
    if (RX_ON && stop_ok) m_cmd = b;
    vectors++;
    assert (pulse_cnt == exp_pulses) else begin
      miscompares++;
      $error("FAIL rx_pulse: got %0d cycles expected %0d", pulse_cnt, exp_pulses);
    end
    vectors++;
    assert (bus.debug_command === m_cmd) else begin
      miscompares++;
      $error("FAIL rx_cmd: got %h expected %h", bus.debug_command, m_cmd);
    end
  endtask

  initial begin
    bus.data_in          = 16'hA55A;
    bus.debug_uart_rx_in = 1'b1;
    reset                = 1'b0;
    repeat (3) step();
    vectors++;
    assert (bus.debug_command === 8'h00) else begin
      miscompares++;
      $error("FAIL reset_cmd: got %h expected 00", bus.debug_command);
    end
    vectors++;
    assert (bus.debug_command_pulse === 1'b0) else begin
      miscompares++;
      $error("FAIL reset_pulse: got %b expected 0", bus.debug_command_pulse);
    end

    // Basic frame, with data_in changed mid-frame (snapshot check).
    reset = 1'b1;
    repeat (15 + 40) step();
    bus.data_in = 16'h1234;
    repeat (200) step();

    // RX: valid command, framing error, then a valid random command.
    rx_send(8'h64, 1'b1);
    rx_send(8'h64, 1'b0);
    rx_send(8'($urandom_range(0, 255)), 1'b1);

    // Reset in the middle of byte 0.
    for (int i = 0; i < 100 && bus.debug_command_busy !== 1'b1; i++) step();
    vectors++;
    assert (bus.debug_command_busy === 1'b1) else begin
      miscompares++;
      $error("FAIL wait_busy: got %b expected 1", bus.debug_command_busy);
    end
    repeat (10) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.data_in = 16'hC33C;
    repeat (150) step();

    // Randomized frames and commands running together.
    for (int n = 0; n < 4; n++) begin
      bus.data_in = 16'($urandom_range(0, 65535));
      repeat (20) step();
      rx_send(8'($urandom_range(0, 255)), 1'b1);
      repeat (60) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
